inst_fetch_queue: RTL

- Fetch front-end upstream of the single-cycle datapath.
- Issues sequential 32-bit instruction reads to an external instruction memory with variable latency, then buffers the returned words with their PCs in a small FIFO.
- Presents one instruction per cycle to decode through a valid/ready handshake.
- Accepts a redirect (taken branch or unconditional branch target) that flushes all queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/inst_fetch_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared widths and the queued fetch entry layout for the instruction fetch front-end.
package fetch_pkg;

  localparam int INST_W     = 32;
  localparam int ADDR_W     = 64;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; the head entry is read straight from storage.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (resetl || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !resetl) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front-end: issues sequential reads, tags them with their PC, buffers responses for decode
// and drops responses that were in flight across a redirect.
module inst_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int MAX_OUTS   = 2,
  parameter int INST_BYTES = fetch_pkg::INST_BYTES
) (
  input  logic                        CLK,
  input  logic                        resetl,
  input  logic [fetch_pkg::ADDR_W-1:0] startpc,
  output logic                        mem_req,
  output logic [fetch_pkg::ADDR_W-1:0] mem_addr,
  input  logic                        mem_gnt,
  input  logic                        mem_rvalid,
  input  logic [fetch_pkg::INST_W-1:0] mem_rdata,
  output logic                        inst_valid,
  output logic [fetch_pkg::INST_W-1:0] inst,
  output logic [fetch_pkg::ADDR_W-1:0] inst_pc,
  input  logic                        inst_ready,
  input  logic                        redirect,
  input  logic [fetch_pkg::ADDR_W-1:0] redirect_pc
);
  import fetch_pkg::*;

  localparam int FCW = $clog2(DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTS + 1);
  localparam int CW  = $clog2(DEPTH + 1) + 1;

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0]     outstanding_reg, outstanding_next;
  logic [CW-1:0]     drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]     in_flight;
  logic [FCW-1:0]    fifo_count;
  logic [TCW-1:0]    tag_count;
  logic [ADDR_W-1:0] tag_pc;
  fetch_entry_t      head_entry;
  fetch_entry_t      push_entry;
  logic              grant;
  logic              resp_keep;
  logic              resp_drop;
  logic              pop;

  // Every request still owed by memory, kept or stale, reserves a FIFO slot.
  assign in_flight = outstanding_reg + drop_cnt_reg;
  assign mem_req   = !resetl && !redirect
                     && ((CW'(fifo_count) + in_flight) < CW'(DEPTH))
                     && (in_flight < CW'(MAX_OUTS));
  assign mem_addr  = fetch_pc_reg;
  assign grant     = mem_req && mem_gnt;

  assign resp_drop = mem_rvalid && (drop_cnt_reg != '0);
  assign resp_keep = mem_rvalid && (drop_cnt_reg == '0) && (tag_count != '0);

  assign inst_valid = !resetl && (fifo_count != '0);
  assign inst       = inst_valid ? head_entry.inst : '0;
  assign inst_pc    = inst_valid ? head_entry.pc : '0;
  assign pop        = inst_valid && inst_ready;

  assign push_entry = '{inst: mem_rdata, pc: tag_pc};

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    if (redirect) begin
      fetch_pc_next    = redirect_pc;
      outstanding_next = '0;
      // A response landing this cycle retires one of the requests being written off.
      drop_cnt_next    = in_flight - CW'(mem_rvalid && (in_flight != '0));
    end else begin
      if (grant) fetch_pc_next = fetch_pc_reg + ADDR_W'(INST_BYTES);
      outstanding_next = outstanding_reg + CW'(grant) - CW'(resp_keep);
      if (resp_drop) drop_cnt_next = drop_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (resetl) begin
      fetch_pc_reg    <= startpc;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      assert (!(mem_rvalid && (in_flight == '0)));
    end
  end

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_fifo (
    .clk       (CLK),
    .resetl    (resetl),
    .flush     (redirect),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTS)) u_tag_queue (
    .clk       (CLK),
    .resetl    (resetl),
    .flush     (redirect),
    .push      (grant),
    .push_data (fetch_pc_reg),
    .pop       (resp_keep),
    .head_data (tag_pc),
    .count     (tag_count)
  );

endmodule
